fg_config_loader: RTL and testbench

- Upstream stage of the function generator: assembles the 64-bit configuration word from a byte-wide valid/ready stream into a shadow register.
- Transfers the shadow to the active CR bus only on a sample boundary (the generator's output-valid strobe) or while output is disabled, so waveform, prescaler and mode change glitch-free.
- The active register drives the function generator's CR bus input directly.

---
 rtl/fg_config_loader.sv | 180 ++++++++++++++++++
 tb/tb_fg_config_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fg_config_loader.sv
// Purpose     : assembles the 64-bit function-generator config word from a byte stream and commits it glitch-free.
// Latency     : commit on the edge after the first cycle in PENDING where sampleStrobe_i | !outputEnable_i holds
//               (2 edges after the last beat when output is disabled); immediate mode commits on the last-beat edge.
// Backpressure: dataReady_o drops only while a complete word waits in PENDING; never in immediate mode.
//
// Optional feature macro: FG_CFG_IMMEDIATE_COMMIT_EN
//   defined   -> no PENDING state; the word is committed on the edge that accepts the last beat.
//   undefined -> the word waits in PENDING for a sample boundary or disabled output.
//
// Ports:
//   clk_i            system clock, rising edge
//   rstn_i           asynchronous active-low reset
//   frameStart_i     one-cycle pulse, starts/restarts a frame (highest priority)
//   data_i           stream beat, first beat lands in the MSB byte
//   dataValid_i      beat valid
//   dataReady_o      loader can take a beat this cycle (derived from registered state only)
//   sampleStrobe_i   generator output-valid strobe, the commit point
//   outputEnable_i   generator output enable; while low, commits need no strobe
//   CR_bus_o         active configuration word to the generator
//   configUpdated_o  one-cycle pulse after CR_bus_o has changed
//   frameError_o     sticky: beat seen outside a frame; cleared by frameStart_i
//   busy_o           state is not IDLE
module fg_config_loader #(
   parameter int CONFIG_REG_BITWIDTH = 64,
   parameter int DATA_BITWIDTH       = 8,
   parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG = '0
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic                           frameStart_i,
   input  logic [DATA_BITWIDTH-1:0]       data_i,
   input  logic                           dataValid_i,
   output logic                           dataReady_o,
   input  logic                           sampleStrobe_i,
   input  logic                           outputEnable_i,
   output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
   output logic                           configUpdated_o,
   output logic                           frameError_o,
   output logic                           busy_o
);

   localparam int BEAT_COUNT = CONFIG_REG_BITWIDTH / DATA_BITWIDTH;
   localparam int PTR_W      = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BEAT_COUNT - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   logic [1:0]                     state_q,  state_d;
   logic [PTR_W-1:0]               ptr_q,    ptr_d;
   logic [CONFIG_REG_BITWIDTH-1:0] shadow_q, shadow_d;
   logic [CONFIG_REG_BITWIDTH-1:0] cr_q,     cr_d;
   logic                           upd_q,    upd_d;
   logic                           err_q,    err_d;

   logic                           beat_acc;
   logic [PTR_W-1:0]               slot;
   logic [CONFIG_REG_BITWIDTH-1:0] shadow_wr;

   // Ready comes from the state register alone so it never combinationally
   // depends on dataValid_i.
`ifdef FG_CFG_IMMEDIATE_COMMIT_EN
   assign dataReady_o = 1'b1;

   // Strobe and enable have no effect in this build.
   logic unused_commit_inputs;
   assign unused_commit_inputs = sampleStrobe_i ^ outputEnable_i;
`else
   assign dataReady_o = (state_q != ST_PEND);
`endif

   assign beat_acc = dataValid_i & dataReady_o;

   // A beat arriving together with frameStart_i is always beat 0, whatever
   // the pointer held from an abandoned frame.
   assign slot = frameStart_i ? '0 : ptr_q;

   // Shadow with the current beat merged in; byte 0 is the most significant.
   always_comb begin
      shadow_wr = shadow_q;
      for (int b = 0; b < BEAT_COUNT; b++) begin
         if (slot == PTR_W'(b)) begin
            shadow_wr[(BEAT_COUNT-1-b)*DATA_BITWIDTH +: DATA_BITWIDTH] = data_i;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      shadow_d = shadow_q;
      cr_d     = cr_q;
      upd_d    = 1'b0;
      err_d    = err_q;

      if (frameStart_i) begin
         // Restart wins over everything, including a commit due this cycle.
         state_d = ST_LOAD;
         ptr_d   = '0;
         err_d   = 1'b0;
         if (beat_acc) begin
            shadow_d = shadow_wr;
            ptr_d    = PTR_W'(1);
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Beat outside a frame: dropped, flagged.
               if (beat_acc) begin
                  err_d = 1'b1;
               end
            end

            ST_LOAD: begin
               if (beat_acc) begin
                  shadow_d = shadow_wr;
                  if (ptr_q == LAST_PTR) begin
                     ptr_d = '0;
`ifdef FG_CFG_IMMEDIATE_COMMIT_EN
                     state_d = ST_IDLE;
                     cr_d    = shadow_wr;
                     upd_d   = 1'b1;
`else
                     // Commit is evaluated from the next cycle on, never
                     // together with the last beat.
                     state_d = ST_PEND;
`endif
                  end else begin
                     ptr_d = ptr_q + PTR_W'(1);
                  end
               end
            end

            ST_PEND: begin
`ifdef FG_CFG_IMMEDIATE_COMMIT_EN
               state_d = ST_IDLE;
`else
               // Swap only on a sample boundary or while nothing is being
               // output, so the generator never sees a half-old word.
               if (sampleStrobe_i | ~outputEnable_i) begin
                  cr_d    = shadow_q;
                  upd_d   = 1'b1;
                  state_d = ST_IDLE;
               end
`endif
            end

            default: begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         shadow_q <= '0;
         cr_q     <= RESET_CONFIG;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         shadow_q <= shadow_d;
         cr_q     <= cr_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
      end
   end

   assign CR_bus_o        = cr_q;
   assign configUpdated_o = upd_q;
   assign frameError_o    = err_q;
   assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fg_config_loader.sv
// Purpose     : self-checking bench for fg_config_loader (stimulus process plus commit monitor with expect queue).
// Latency     : checks commit timing for both the strobe-synchronised and immediate-commit builds.
// Backpressure: beats are only driven while the loader is ready.
module tb_fg_config_loader;

   localparam logic [63:0] RST_CFG = 64'hA000_0000_0000_0000;

   logic        clk;
   logic        rst_n;
   logic        fs;
   logic [7:0]  dat;
   logic        vld;
   logic        rdy;
   logic        strobe;
   logic        oe;
   logic [63:0] cr;
   logic        upd;
   logic        err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];
   logic        prev_upd = 1'b0;

   fg_config_loader #(
      .CONFIG_REG_BITWIDTH(64),
      .DATA_BITWIDTH      (8),
      .RESET_CONFIG       (RST_CFG)
   ) dut (
      .clk_i          (clk),
      .rstn_i         (rst_n),
      .frameStart_i   (fs),
      .data_i         (dat),
      .dataValid_i    (vld),
      .dataReady_o    (rdy),
      .sampleStrobe_i (strobe),
      .outputEnable_i (oe),
      .CR_bus_o       (cr),
      .configUpdated_o(upd),
      .frameError_o   (err),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every update pulse must match the oldest expected word and
   // last exactly one cycle.
   always @(negedge clk) begin
      if (upd === 1'b1) begin
         chk("upd_pulse_width", {63'd0, prev_upd}, 64'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: got %h expected no update at %0t", cr, $time);
         end else begin
            chk("commit_word", cr, exp_q.pop_front());
         end
      end
      prev_upd = upd;
   end

   // One beat, accepted at the next rising edge; returns 1ns after it.
   task automatic beat(input logic [7:0] d, input logic start);
      dat = d;
      vld = 1'b1;
      fs  = start;
      @(posedge clk);
      #1;
      vld = 1'b0;
      fs  = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] w);
      for (int i = 0; i < 8; i++) begin
         beat(w[63-8*i -: 8], (i == 0));
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      fs     = 1'b0;
      dat    = 8'h00;
      vld    = 1'b0;
      strobe = 1'b0;
      oe     = 1'b1;

      // Reset state.
      #12;
      chk("rst_cr",   cr,   RST_CFG);
      chk("rst_rdy",  {63'd0, rdy},  64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_err",  {63'd0, err},  64'd0);
      chk("rst_upd",  {63'd0, upd},  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Strobe-synchronised commit with output enabled.
      exp_q.push_back(64'h0102030405060708);
      send_word(64'h0102030405060708);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
`ifdef FG_CFG_IMMEDIATE_COMMIT_EN
         chk("imm_cr_early",  cr, 64'h0102030405060708);
         chk("imm_rdy",       {63'd0, rdy}, 64'd1);
`else
         chk("pend_cr_old",   cr, RST_CFG);
         chk("pend_rdy_low",  {63'd0, rdy}, 64'd0);
         chk("pend_busy",     {63'd0, busy}, 64'd1);
`endif
      end
      strobe = 1'b1;
      @(posedge clk);
      #1;
      strobe = 1'b0;
      @(negedge clk);
      chk("strobe_cr_new", cr, 64'h0102030405060708);
      chk("strobe_rdy",    {63'd0, rdy}, 64'd1);
      chk("strobe_idle",   {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("upd_dropped",   {63'd0, upd}, 64'd0);

      // Output disabled: visible two edges after the last beat, no strobe.
      // A different word is used so the change is observable on CR_bus_o.
      oe = 1'b0;
      exp_q.push_back(64'h1112131415161718);
      send_word(64'h1112131415161718);
      @(negedge clk);
`ifdef FG_CFG_IMMEDIATE_COMMIT_EN
      chk("oe0_cr_edge1", cr, 64'h1112131415161718);
`else
      chk("oe0_cr_edge1", cr, 64'h0102030405060708);
`endif
      @(negedge clk);
      chk("oe0_cr_edge2", cr, 64'h1112131415161718);

      // Restart mid-frame with a beat in the restart cycle.
      exp_q.push_back(64'hFF11223344556677);
      beat(8'hAA, 1'b1);
      beat(8'hBB, 1'b0);
      beat(8'hCC, 1'b0);
      beat(8'hFF, 1'b1);
      for (int i = 1; i < 8; i++) begin
         beat(8'(i * 8'h11), 1'b0);
      end
      repeat (3) @(negedge clk);
      chk("restart_cr", cr, 64'hFF11223344556677);

      // Stray beat in IDLE.
      beat(8'h55, 1'b0);
      @(negedge clk);
      chk("stray_err",  {63'd0, err}, 64'd1);
      chk("stray_cr",   cr, 64'hFF11223344556677);
      chk("stray_busy", {63'd0, busy}, 64'd0);
      fs = 1'b1;
      @(posedge clk);
      #1;
      fs = 1'b0;
      @(negedge clk);
      chk("fs_clears_err", {63'd0, err}, 64'd0);
      chk("fs_busy",       {63'd0, busy}, 64'd1);

      // Asynchronous reset after four beats of a frame.
      beat(8'h01, 1'b1);
      beat(8'h02, 1'b0);
      beat(8'h03, 1'b0);
      beat(8'h04, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cr",   cr, RST_CFG);
      chk("async_rst_busy", {63'd0, busy}, 64'd0);
      chk("async_rst_rdy",  {63'd0, rdy}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(64'hDEADBEEFCAFEF00D);
      send_word(64'hDEADBEEFCAFEF00D);
      repeat (3) @(negedge clk);
      chk("post_rst_cr", cr, 64'hDEADBEEFCAFEF00D);

      // Back-to-back frames: second frameStart in the cycle after the commit.
      exp_q.push_back(64'h0011223344556677);
      exp_q.push_back(64'h8899AABBCCDDEEFF);
      send_word(64'h0011223344556677);
`ifndef FG_CFG_IMMEDIATE_COMMIT_EN
      @(posedge clk);
      #1;
`endif
      send_word(64'h8899AABBCCDDEEFF);
      repeat (3) @(negedge clk);
      chk("b2b_cr", cr, 64'h8899AABBCCDDEEFF);

      repeat (4) @(negedge clk);
      chk("all_commits_seen", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
